// File: rtl/wdg_pkg.sv
// Shared constants for the watchdog family: register map, CSR bit positions,
// reset-controller FSM states and the IWDG start key.
package wdg_pkg;

    localparam logic [31:0] OFF_RST_CSR = 32'h0000_0000;
    localparam logic [31:0] OFF_RST_LEN = 32'h0000_0004;
    localparam logic [31:0] OFF_RST_CNT = 32'h0000_0008;

    localparam logic [1:0] REG_CSR = 2'd0;
    localparam logic [1:0] REG_LEN = 2'd1;
    localparam logic [1:0] REG_CNT = 2'd2;

    localparam int CSR_IWDGRSTF = 0;
    localparam int CSR_WWDGRSTF = 1;
    localparam int CSR_SFTRSTF  = 2;
    localparam int CSR_PORRSTF  = 3;
    localparam int CSR_RMVF     = 24;
    localparam int CSR_SWRST    = 31;

    localparam int LEN_RST_DEF = 16;

    localparam logic [15:0] IWDG_KEY_START = 16'hCCCC;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ASSERT = 2'd1,
        ST_HOLD   = 2'd2
    } rst_state_e;

endpackage

// File: rtl/wb_reg_slave.sv
// Wishbone slave for a three-register block: address decode, single-cycle
// registered ack/err, registered read mux, and a write strobe aligned with ack.
module wb_reg_slave
    import wdg_pkg::*;
#(
    parameter logic [31:0] BASE_ADR = 32'h0100_0100
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] adr_i,
    input  logic [31:0] dat_i,
    input  logic        cyc_i,
    input  logic        stb_i,
    input  logic        we_i,
    input  logic [31:0] rd_csr_i,
    input  logic [31:0] rd_len_i,
    input  logic [31:0] rd_cnt_i,
    output logic [31:0] dat_o,
    output logic        ack_o,
    output logic        err_o,
    output logic        rty_o,
    output logic        wr_o,
    output logic [1:0]  wr_idx_o,
    output logic [31:0] wr_dat_o
);

    logic        ack_q, err_q, wr_q;
    logic [1:0]  wr_idx_q;
    logic [31:0] wr_dat_q, dat_q;
    logic        req_s, hit_s;
    logic [1:0]  idx_s;
    logic [31:0] rdat_s;

    // A held strobe is answered only once: the cycle after a termination is a gap.
    assign req_s = cyc_i & stb_i & ~ack_q & ~err_q;

    // Address decode and read data selection.
    always_comb begin
        hit_s  = 1'b1;
        idx_s  = REG_CSR;
        rdat_s = 32'h0000_0000;
        case (adr_i)
            BASE_ADR + OFF_RST_CSR: begin idx_s = REG_CSR; rdat_s = rd_csr_i; end
            BASE_ADR + OFF_RST_LEN: begin idx_s = REG_LEN; rdat_s = rd_len_i; end
            BASE_ADR + OFF_RST_CNT: begin idx_s = REG_CNT; rdat_s = rd_cnt_i; end
            default:                begin hit_s = 1'b0; end
        endcase
    end

    // Termination, read data and write strobe registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            wr_q     <= 1'b0;
            wr_idx_q <= REG_CSR;
            wr_dat_q <= 32'h0000_0000;
            dat_q    <= 32'h0000_0000;
        end else begin
            ack_q    <= req_s & hit_s;
            err_q    <= req_s & ~hit_s;
            wr_q     <= req_s & hit_s & we_i;
            wr_idx_q <= idx_s;
            wr_dat_q <= dat_i;
            dat_q    <= (req_s & hit_s & ~we_i) ? rdat_s : 32'h0000_0000;
        end
    end

    assign dat_o    = dat_q;
    assign ack_o    = ack_q;
    assign err_o    = err_q;
    assign rty_o    = 1'b0;
    assign wr_o     = wr_q;
    assign wr_idx_o = wr_idx_q;
    assign wr_dat_o = wr_dat_q;

endmodule

// File: rtl/wdg_rst_ctrl.sv
// Reset controller behind the watchdogs: turns IWDG/WWDG/software requests into a
// stretched system reset and keeps sticky cause flags plus an event counter.
module wdg_rst_ctrl
    import wdg_pkg::*;
#(
    parameter int          GRL      = 1,
    parameter logic [31:0] BASE_ADR = 32'h0100_0100,
    parameter int          LEN_W    = 8,
    parameter int          CNT_W    = 8,
    parameter int          LEN_RST  = LEN_RST_DEF
) (
    input  logic           clk_m2s,
    input  logic           rst_m2s,
    input  logic [31:0]    dat_m2s,
    input  logic [31:0]    adr_m2s,
    input  logic [GRL:0]   sel_m2s,
    input  logic           cyc_m2s,
    input  logic           stb_m2s,
    input  logic           we_m2s,
    input  logic           lok_m2s,
    input  logic           rst_iwdg,
    input  logic           rst_wwdg,
    output logic [31:0]    dat_s2m,
    output logic           ack_s2m,
    output logic           err_s2m,
    output logic           rty_s2m,
    output logic           sys_rst
);

    logic             wr_s;
    logic [1:0]       wr_idx_s;
    logic [31:0]      wr_dat_s;
    logic             unused_s;

    logic             iwdg_s1_q, iwdg_s2_q, wwdg_s1_q, wwdg_s2_q;
    logic [3:0]       flags_q, flags_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] dcnt_q, dcnt_d;
    rst_state_e       state_q, state_d;
    logic             sys_rst_q;

    logic             iw_evt_s, ww_evt_s, sw_evt_s, rmv_s, evt_s, level_s;
    logic [LEN_W-1:0] load_s;

    assign unused_s = ^{sel_m2s, lok_m2s, wr_dat_s};

    wb_reg_slave #(.BASE_ADR(BASE_ADR)) u_slave (
        .clk_i    (clk_m2s),
        .rst_i    (rst_m2s),
        .adr_i    (adr_m2s),
        .dat_i    (dat_m2s),
        .cyc_i    (cyc_m2s),
        .stb_i    (stb_m2s),
        .we_i     (we_m2s),
        .rd_csr_i ({28'h000_0000, flags_q}),
        .rd_len_i ({{(32-LEN_W){1'b0}}, len_q}),
        .rd_cnt_i ({{(32-CNT_W){1'b0}}, cnt_q}),
        .dat_o    (dat_s2m),
        .ack_o    (ack_s2m),
        .err_o    (err_s2m),
        .rty_o    (rty_s2m),
        .wr_o     (wr_s),
        .wr_idx_o (wr_idx_s),
        .wr_dat_o (wr_dat_s)
    );

    assign iw_evt_s = iwdg_s1_q & ~iwdg_s2_q;
    assign ww_evt_s = wwdg_s1_q & ~wwdg_s2_q;
    assign sw_evt_s = wr_s & (wr_idx_s == REG_CSR) & wr_dat_s[CSR_SWRST];
    assign rmv_s    = wr_s & (wr_idx_s == REG_CSR) & wr_dat_s[CSR_RMVF];
    assign evt_s    = iw_evt_s | ww_evt_s | sw_evt_s;
    assign level_s  = iwdg_s1_q | wwdg_s1_q;
    assign load_s   = (len_q == {LEN_W{1'b0}}) ? LEN_W'(1) : len_q;

    // Cause flags, event counter and length register next-state.
    always_comb begin
        flags_d = flags_q & ~{4{rmv_s}};
        flags_d = flags_d | {1'b0, sw_evt_s, ww_evt_s, iw_evt_s};
        cnt_d   = cnt_q;
        len_d   = len_q;
        if (rmv_s) begin
            cnt_d = evt_s ? CNT_W'(1) : {CNT_W{1'b0}};
        end else if (evt_s && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
        if (wr_s && (wr_idx_s == REG_LEN)) begin
            len_d = wr_dat_s[LEN_W-1:0];
        end else begin
            len_d = len_q;
        end
    end

    // Reset-pulse FSM: any new event (re)loads the stretch counter.
    always_comb begin
        state_d = state_q;
        dcnt_d  = dcnt_q;
        case (state_q)
            ST_IDLE: begin
                if (evt_s) begin
                    state_d = ST_ASSERT;
                    dcnt_d  = load_s;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ASSERT: begin
                if (evt_s) begin
                    dcnt_d = load_s;
                end else if (dcnt_q == LEN_W'(1)) begin
                    state_d = level_s ? ST_HOLD : ST_IDLE;
                end else begin
                    dcnt_d = dcnt_q - LEN_W'(1);
                end
            end
            ST_HOLD: begin
                if (evt_s) begin
                    state_d = ST_ASSERT;
                    dcnt_d  = load_s;
                end else if (!level_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; edge history clears so a request high at release is seen.
    always_ff @(posedge clk_m2s) begin
        if (rst_m2s) begin
            iwdg_s1_q <= 1'b0;
            iwdg_s2_q <= 1'b0;
            wwdg_s1_q <= 1'b0;
            wwdg_s2_q <= 1'b0;
            flags_q   <= 4'b1000;
            cnt_q     <= {CNT_W{1'b0}};
            len_q     <= LEN_W'(LEN_RST);
            dcnt_q    <= {LEN_W{1'b0}};
            state_q   <= ST_IDLE;
            sys_rst_q <= 1'b0;
        end else begin
            iwdg_s1_q <= rst_iwdg;
            iwdg_s2_q <= iwdg_s1_q;
            wwdg_s1_q <= rst_wwdg;
            wwdg_s2_q <= wwdg_s1_q;
            flags_q   <= flags_d;
            cnt_q     <= cnt_d;
            len_q     <= len_d;
            dcnt_q    <= dcnt_d;
            state_q   <= state_d;
            sys_rst_q <= (state_d != ST_IDLE);
        end
    end

    assign sys_rst = sys_rst_q;

endmodule
